// File: rtl/mem_pkg.sv
// Shared types and widths for the unified instruction/data memory responder.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ACK
    } mem_state_t;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned STAT_W = 16;

    // Saturating increment for the statistics counters.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + STAT_W'(1) : v;
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word RAM with registered read data; contents are never reset.
module mem_array
    import mem_pkg::*;
#(
    parameter int unsigned Depth = 256,
    parameter int unsigned IdxW  = 8
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [IdxW-1:0]   idx_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [Depth];
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
        rdata_q <= mem_q[idx_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Request/acknowledge memory responder with fixed wait states and address error checking.
// Optional statistics counters are enabled by defining MEM_RESPONDER_STATS_EN.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [WORD_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic              ack,
    output logic              err
`ifdef MEM_RESPONDER_STATS_EN
    ,
    output logic [STAT_W-1:0] rd_count,
    output logic [STAT_W-1:0] wr_count,
    output logic [STAT_W-1:0] err_count
`endif
);

    localparam int unsigned IdxW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [29:0] DepthLim = 30'(DEPTH_WORDS);
    localparam logic [3:0]  WaitLd   = 4'(WAIT_CYCLES);

    mem_state_t        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;

    logic              accept;
    logic              done;
    logic              addr_bad;
    logic              mem_we;
    logic [IdxW-1:0]   mem_idx;
    logic [WORD_W-1:0] arr_rdata;

    assign accept   = req && ((state_q == IDLE) || (state_q == ACK));
    assign done     = (state_q == BUSY) && (cnt_q == 4'd0);
    assign addr_bad = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= DepthLim);
    assign mem_we   = done && !addr_bad && we_q && !reset;
    // Steer the incoming index on acceptance so read data is ready even with zero wait states.
    assign mem_idx  = accept ? addr[IdxW+1:2] : addr_q[IdxW+1:2];

    mem_array #(
        .Depth (DEPTH_WORDS),
        .IdxW  (IdxW)
    ) u_array (
        .clk_i   (clk),
        .we_i    (mem_we),
        .idx_i   (mem_idx),
        .wdata_i (wdata_q),
        .rdata_o (arr_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE, ACK: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
                    cnt_d   = WaitLd;
                    state_d = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    ack_d   = 1'b1;
                    err_d   = addr_bad;
                    state_d = ACK;
                    if (!addr_bad && !we_q) begin
                        rdata_d = arr_rdata;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign rdata = rdata_q;
    assign ack   = ack_q;
    assign err   = err_q;

`ifdef MEM_RESPONDER_STATS_EN
    logic [STAT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [STAT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [STAT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        rd_cnt_d  = sat_inc(rd_cnt_q, done && !addr_bad && !we_q);
        wr_cnt_d  = sat_inc(wr_cnt_q, done && !addr_bad && we_q);
        err_cnt_d = sat_inc(err_cnt_q, done && addr_bad);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign rd_count  = rd_cnt_q;
    assign wr_count  = wr_cnt_q;
    assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench: a WAIT_CYCLES=2 instance for single accesses and a WAIT_CYCLES=0
// instance for back-to-back bursts, both checked against an array-based reference model.
module tb_mem_responder;
    import mem_pkg::*;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned WAIT_A = 2;
    localparam int unsigned WAIT_B = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
    logic [31:0] addr_a = '0, wdata_a = '0, addr_b = '0, wdata_b = '0;
    logic [31:0] rdata_a, rdata_b;
    logic ack_a, err_a, ack_b, err_b;
`ifdef MEM_RESPONDER_STATS_EN
    logic [15:0] rdc_a, wrc_a, erc_a, rdc_b, wrc_b, erc_b;
`endif

    always #5 clk = ~clk;

    mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAIT_A)) dut (
        .clk(clk), .reset(reset), .req(req_a), .we(we_a), .addr(addr_a), .wdata(wdata_a),
        .rdata(rdata_a), .ack(ack_a), .err(err_a)
`ifdef MEM_RESPONDER_STATS_EN
        , .rd_count(rdc_a), .wr_count(wrc_a), .err_count(erc_a)
`endif
    );

    mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAIT_B)) dut0 (
        .clk(clk), .reset(reset), .req(req_b), .we(we_b), .addr(addr_b), .wdata(wdata_b),
        .rdata(rdata_b), .ack(ack_b), .err(err_b)
`ifdef MEM_RESPONDER_STATS_EN
        , .rd_count(rdc_b), .wr_count(wrc_b), .err_count(erc_b)
`endif
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    logic [31:0] mm [2][DEPTH];
    logic [31:0] m_rdata [2];
    int m_rd [2];
    int m_wr [2];
    int m_er [2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: decides the outcome of an access from the address rules alone.
    function automatic exp_t predict(input int d, input logic w, input logic [31:0] a,
                                     input logic [31:0] wd);
        exp_t e;
        logic bad;
        bad = (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH);
        if (bad) m_er[d]++;
        else if (w) begin
            mm[d][a[9:2]] = wd;
            m_wr[d]++;
        end else begin
            m_rdata[d] = mm[d][a[9:2]];
            m_rd[d]++;
        end
        e.rdata = m_rdata[d];
        e.err = bad;
        e.cyc = 0;
        return e;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_rdata[d] = '0;
            m_rd[d] = 0;
            m_wr[d] = 0;
            m_er[d] = 0;
        end
    endtask

    // Monitor: every ack must match the oldest queued expectation, including its cycle.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (ack_a) begin
            if (q_a.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_ack_a: got ack=1 expected no ack (cycle %0d)", cyc);
            end else begin
                e = q_a.pop_front();
                check("rdata_a", rdata_a, e.rdata);
                check("err_a", {31'd0, err_a}, {31'd0, e.err});
                check("ack_cycle_a", cyc, e.cyc);
            end
        end
        if (ack_b) begin
            if (q_b.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_ack_b: got ack=1 expected no ack (cycle %0d)", cyc);
            end else begin
                e = q_b.pop_front();
                check("rdata_b", rdata_b, e.rdata);
                check("err_b", {31'd0, err_b}, {31'd0, e.err});
                check("ack_cycle_b", cyc, e.cyc);
            end
        end
    end

    // Single access on the WAIT_CYCLES=2 instance; req drops during the ack cycle.
    task automatic access_a(input logic w, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        int n;
        @(negedge clk);
        req_a = 1'b1; we_a = w; addr_a = a; wdata_a = d;
        e = predict(0, w, a, d);
        e.cyc = cyc + int'(WAIT_A) + 2;
        q_a.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack_a && n < 40);
        if (!ack_a) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout_a: got no ack expected ack within 40 cycles");
        end
        req_a = 1'b0;
    endtask

    // Present the next request on the WAIT_CYCLES=0 instance at the current negedge.
    task automatic issue_b(input logic w, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        req_b = 1'b1; we_b = w; addr_b = a; wdata_b = d;
        e = predict(1, w, a, d);
        e.cyc = cyc + int'(WAIT_B) + 2;
        q_b.push_back(e);
    endtask

    task automatic wait_ack_b();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack_b && n < 40);
        if (!ack_b) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout_b: got no ack expected ack within 40 cycles");
        end
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        int k;
        k = $urandom_range(0, 9);
        a = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        if (k == 0) a[1:0] = 2'($urandom_range(1, 3));
        else if (k == 1) a[31:10] = 22'($urandom_range(1, 4194303));
        return a;
    endfunction

    task automatic check_idle_outputs();
        check("reset_rdata_a", rdata_a, 32'h0);
        check("reset_ack_a", {31'd0, ack_a}, 32'h0);
        check("reset_err_a", {31'd0, err_a}, 32'h0);
        check("reset_state_a", 32'(dut.state_q), 32'(IDLE));
        check("reset_rdata_b", rdata_b, 32'h0);
        check("reset_state_b", 32'(dut0.state_q), 32'(IDLE));
    endtask

`ifdef MEM_RESPONDER_STATS_EN
    task automatic check_stats();
        check("rd_count_a", {16'd0, rdc_a}, 32'(m_rd[0]));
        check("wr_count_a", {16'd0, wrc_a}, 32'(m_wr[0]));
        check("err_count_a", {16'd0, erc_a}, 32'(m_er[0]));
        check("rd_count_b", {16'd0, rdc_b}, 32'(m_rd[1]));
        check("wr_count_b", {16'd0, wrc_b}, 32'(m_wr[1]));
        check("err_count_b", {16'd0, erc_b}, 32'(m_er[1]));
    endtask
`endif

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [31:0] v;
        for (int i = 0; i < int'(DEPTH); i++) begin
            v = $urandom();
            dut.u_array.mem_q[i] = v;
            mm[0][i] = v;
            v = $urandom();
            dut0.u_array.mem_q[i] = v;
            mm[1][i] = v;
        end
        dut.u_array.mem_q[8] = 32'h0;
        mm[0][8] = 32'h0;
        dut0.u_array.mem_q[0] = 32'h11;
        mm[1][0] = 32'h11;
        dut0.u_array.mem_q[1] = 32'h22;
        mm[1][1] = 32'h22;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs();

        // Write then read back, error accesses, then confirm memory untouched.
        access_a(1'b1, 32'h10, 32'hDEADBEEF);
        access_a(1'b0, 32'h10, 32'h0);
        access_a(1'b1, 32'h13, 32'h12345678);
        access_a(1'b1, DEPTH * 4, 32'h87654321);
        access_a(1'b0, 32'h10, 32'h0);
        access_a(1'b0, 32'h11, 32'h0);

        // Back-to-back reads with req held high on the zero-wait instance.
        @(negedge clk);
        issue_b(1'b0, 32'h0, 32'h0);
        wait_ack_b();
        issue_b(1'b0, 32'h4, 32'h0);
        wait_ack_b();
        req_b = 1'b0;

        // Reset while the write is in BUSY: nothing commits, no ack.
        @(negedge clk);
        req_a = 1'b1; we_a = 1'b1; addr_a = 32'h20; wdata_a = 32'hCAFEF00D;
        @(negedge clk);
        reset = 1'b1;
        req_a = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (5) @(negedge clk);
        check_idle_outputs();
        access_a(1'b0, 32'h20, 32'h0);

        for (int i = 0; i < 40; i++) begin
            access_a(1'($urandom_range(0, 1)), rand_addr(), $urandom());
        end
        @(negedge clk);
        for (int i = 0; i < 30; i++) begin
            issue_b(1'($urandom_range(0, 1)), rand_addr(), $urandom());
            wait_ack_b();
        end
        req_b = 1'b0;
        repeat (3) @(negedge clk);

`ifdef MEM_RESPONDER_STATS_EN
        check_stats();
        do_reset();
        access_a(1'b0, 32'h0, 32'h0);
        access_a(1'b1, 32'h8, 32'hA5A5A5A5);
        access_a(1'b0, 32'h8, 32'h0);
        access_a(1'b1, 32'hC, 32'h5A5A5A5A);
        access_a(1'b0, 32'h3, 32'h0);
        access_a(1'b0, 32'hC, 32'h0);
        @(negedge clk);
        check("stats_rd_3", {16'd0, rdc_a}, 32'd3);
        check("stats_wr_2", {16'd0, wrc_a}, 32'd2);
        check("stats_err_1", {16'd0, erc_a}, 32'd1);
        check_stats();
        do_reset();
        @(negedge clk);
        check_stats();
`endif

        repeat (4) @(negedge clk);
        check("pending_a", 32'(q_a.size()), 32'd0);
        check("pending_b", 32'(q_b.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Unified instruction/data memory responder for the multi-cycle MIPS core. It serves the single shared memory port that the controller drives: instruction fetches in FETCH and data accesses in MEMRD and MEMWR. It accepts one word access per request/acknowledge handshake, models a fixed number of wait states, and flags misaligned or out-of-range addresses. The core's control FSM holds its current state until `ack` is seen.

## Interface
Parameters:
- `DEPTH_WORDS`, default 256: number of 32-bit words; must be a power of two.
- `WAIT_CYCLES`, default 2: extra wait states per access; legal range 0–15.

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: clock; all state changes on the rising edge.
- `reset` input 1: synchronous active-high reset.
- `req` input 1: access request; level held by the initiator until `ack`.
- `we` input 1: 1 = write, 0 = read; sampled at acceptance.
- `addr` input 32: byte address; sampled at acceptance.
- `wdata` input 32: write data; sampled at acceptance.
- `rdata` output 32: read data; registered.
- `ack` output 1: one-cycle completion pulse; registered.
- `err` output 1: error qualifier, meaningful only while `ack`=1; registered.

## Operation
- States: `IDLE`, `BUSY`, `ACK`.
- Acceptance: when state is `IDLE` or `ACK` and `req`=1 at an edge:
  - latch `we`, `addr` and `wdata`;
  - load `cnt` with `WAIT_CYCLES`;
  - go to `BUSY`.
- `BUSY`, `cnt`≠0: decrement `cnt`. All inputs are ignored.
- `BUSY`, `cnt`=0: perform the access, set `ack`=1, go to `ACK`.
- `ACK` with `req`=0: go to `IDLE`, `ack`=0.
- `ACK` with `req`=1: treated as a new request (see Acceptance), `ack`=0.
- Word index is `addr[31:2]`.
- Error condition: `addr[1:0]`≠0, or `addr[31:2]` ≥ `DEPTH_WORDS`.
  - On error: no write occurs, `rdata` is unchanged, `err`=1.
- Good read: `rdata` ← mem[index], `err`=0.
- Good write: mem[index] ← `wdata`, `rdata` unchanged, `err`=0.
- Memory contents are not initialised by reset. The bench preloads via hierarchical access to the sub-module.

## Timing
- Accepting edge is E0. The access and the `ack` rising edge occur at edge E(`WAIT_CYCLES`+1). `ack` falls at E(`WAIT_CYCLES`+2).
- Throughput: one access per `WAIT_CYCLES`+2 cycles, with back-to-back acceptance at the edge that ends the `ack` cycle.
- Handshake rule: the initiator deasserts `req` during the `ack` cycle unless it is issuing a new request. If `req` is still high at the end of the `ack` cycle, that is a new request.
- `rdata` is stable from the `ack` cycle until the next good read completes.
- Reset values: `rdata`=0, `ack`=0, `err`=0, state `IDLE`, `cnt`=0.
- Reset mid-`BUSY`: the access is aborted and no write is committed. The memory array is retained.
- Reset during the `ack` cycle: `ack` falls at the reset edge. A write already committed stays committed.
- Reset has priority over a simultaneous `req`.

## Configuration
- `MEM_RESPONDER_STATS_EN` defined:
  - adds outputs `rd_count`, `wr_count` and `err_count`, each 16-bit;
  - each counter increments at the completing edge of the matching access: good read, good write, or error respectively;
  - counters saturate at 16'hFFFF and clear on reset.
- `MEM_RESPONDER_STATS_EN` undefined: the ports and the counter logic are absent. All other behaviour is identical.

## Structure
- Package `mem_pkg` holds:
  - `mem_state_t`, an enum of `IDLE`, `BUSY`, `ACK`;
  - `WORD_W` = 32;
  - `STAT_W` = 16.
- Sub-module `mem_array`:
  - single-port synchronous RAM, `DEPTH_WORDS`×32;
  - write enable, index and write data in; registered read data out.
- `mem_responder` contains the FSM, the wait counter, the error check and the optional statistics.

## Test plan
- Reset, then check outputs → `ack`=0, `err`=0, `rdata`=0, state `IDLE`.
- `WAIT_CYCLES`=2. Write `addr`=0x10 with `wdata`=0xDEADBEEF, then read 0x10 → each `ack` rises at E3, read `rdata`=0xDEADBEEF with `err`=0, and the cycle-count check passes.
- `WAIT_CYCLES`=0. Hold `req`=1 continuously over consecutive reads of addresses 0x0 and 0x4, preloaded with 0x11 and 0x22 → `ack` pulses every 2 cycles, `rdata` = 0x11 then 0x22.
- Write to 0x13 (misaligned) and write to `DEPTH_WORDS`×4 (out of range) → `ack`=1 with `err`=1 for each, memory unchanged, `rdata` unchanged.
- Start a write of 0xCAFEF00D to 0x20, then assert `reset` at E1 while in `BUSY` → no `ack`; a subsequent read of 0x20 returns the old value 0x00000000.
- With `MEM_RESPONDER_STATS_EN`: 3 good reads, 2 good writes and 1 error → `rd_count`=3, `wr_count`=2, `err_count`=1. After reset all counters are 0.
